apb_completer_regfile: RTL and testbench

- APB completer (slave) at the far end of the AHB-to-APB down-bridge. It answers the bridge's Psel/Penable transfers with a register bank, programmable wait states and PSLVERR error reporting.
- Provides the responder side the bridge and its APB protocol checks are exercised against: Pready asserts only in ACCESS, and the transfer shape is SETUP then ACCESS.
- Single clock domain (Pclk).

---
 rtl/apb_completer_regfile.sv | 157 +++++++++++++++
 tb/tb_apb_completer_regfile.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_completer_regfile.sv
// APB completer with a small word register bank, programmable wait states
// and PSLVERR reporting for unaligned, out-of-range or read-only accesses.
`timescale 1ns/1ps
module apb_completer_regfile #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        NUM_REGS = 16,
  parameter logic [DATA_W-1:0]  ID_VALUE = 32'hA9B0_0001
) (
  input  logic              Pclk,
  input  logic              Presetn,
  input  logic              Psel,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [ADDR_W-1:0] Paddr,
  input  logic [DATA_W-1:0] Pwdata,
  input  logic [3:0]        wait_cfg,
  output logic [DATA_W-1:0] Prdata,
  output logic              Pready,
  output logic              Pslverr,
  output logic [15:0]       xfer_cnt
);

  localparam int unsigned IW    = ADDR_W - 2;
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                pready_n, pslverr_n;
  logic [DATA_W-1:0]   prdata_n;
  logic [15:0]         xfer_cnt_n;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                setup_c, load_c, wr_en_c;
  logic [ADDR_W-1:0]   resp_addr_c;
  logic                resp_write_c;
  logic [IW-1:0]       resp_idx_c;
  logic                resp_err_c;
  logic [DATA_W-1:0]   resp_data_c;

  // Psel with Penable low is a SETUP in any state; in ACCESS it also aborts.
  assign setup_c = Psel && !Penable;

  // Zero-wait responses are built from the live bus, later ones from the capture.
  always_comb begin
    resp_addr_c  = setup_c ? Paddr  : addr_q;
    resp_write_c = setup_c ? Pwrite : write_q;
    resp_idx_c   = resp_addr_c[ADDR_W-1:2];
    resp_err_c   = (resp_addr_c[1:0] != 2'b00) ||
                   (resp_idx_c >= IW'(NUM_REGS)) ||
                   (resp_write_c && (resp_idx_c == '0));
    resp_data_c  = '0;
    if (!resp_write_c && !resp_err_c) begin
      resp_data_c = (resp_idx_c == '0) ? ID_VALUE : regs[resp_idx_c[IDX_W-1:0]];
    end
  end

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state    <= IDLE;
      cnt      <= '0;
      Pready   <= 1'b0;
      Pslverr  <= 1'b0;
      Prdata   <= '0;
      xfer_cnt <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      Pready   <= pready_n;
      Pslverr  <= pslverr_n;
      Prdata   <= prdata_n;
      xfer_cnt <= xfer_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pready_n   = Pready;
    pslverr_n  = Pslverr;
    prdata_n   = Prdata;
    xfer_cnt_n = xfer_cnt;
    load_c     = 1'b0;
    wr_en_c    = 1'b0;

    if (setup_c) begin
      state_n   = ACCESS;
      cnt_n     = wait_cfg;
      pready_n  = 1'b0;
      pslverr_n = 1'b0;
      prdata_n  = '0;
      load_c    = (wait_cfg == '0);
    end else begin
      case (state)
        IDLE: begin
          pready_n  = 1'b0;
          pslverr_n = 1'b0;
          prdata_n  = '0;
        end
        ACCESS: begin
          if (!(Psel && Penable)) begin
            state_n   = IDLE;
            pready_n  = 1'b0;
            pslverr_n = 1'b0;
            prdata_n  = '0;
          end else if (Pready) begin
            // Pslverr already holds the error verdict for this transfer.
            wr_en_c    = write_q && !Pslverr;
            xfer_cnt_n = xfer_cnt + 16'd1;
            state_n    = IDLE;
            pready_n   = 1'b0;
            pslverr_n  = 1'b0;
            prdata_n   = '0;
          end else begin
            cnt_n  = cnt - CNT_W'(1);
            load_c = (cnt == CNT_W'(1));
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (load_c) begin
      pready_n  = 1'b1;
      pslverr_n = resp_err_c;
      prdata_n  = resp_data_c;
    end
  end

  // Transfer attributes are frozen at SETUP; bus changes during ACCESS are ignored.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (setup_c) begin
      addr_q  <= Paddr;
      write_q <= Pwrite;
      wdata_q <= Pwdata;
    end
  end

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wr_en_c) begin
      regs[addr_q[IDX_W+1:2]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Bench for apb_completer_regfile: directed vector table, abort/reset
// sequences and randomized transfers against a word-array model.
`timescale 1ns/1ps
module tb_apb_completer_regfile;

  localparam logic [31:0] ID  = 32'hA9B0_0001;
  localparam int          NUM = 16;

  logic        Pclk, Presetn, Psel, Penable, Pwrite;
  logic [31:0] Paddr, Pwdata, Prdata;
  logic [3:0]  wait_cfg;
  logic        Pready, Pslverr;
  logic [15:0] xfer_cnt;

  apb_completer_regfile dut (
    .Pclk(Pclk), .Presetn(Presetn), .Psel(Psel), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .wait_cfg(wait_cfg),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr), .xfer_cnt(xfer_cnt)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mregs [NUM];
  int          mxfer;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  ws;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [13];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic model_err(input logic [31:0] a, input logic w);
    logic [31:0] idx;
    idx = a >> 2;
    return (a[1:0] != 2'b00) || (idx >= 32'(NUM)) || (w && idx == 32'd0);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    if (idx == 32'd0) return ID;
    return mregs[idx[3:0]];
  endfunction

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  // One full transfer starting at the current time; ends one step after completion.
  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] ws, input logic exp_err,
                         input logic [31:0] exp_rd, input string nm);
    Psel = 1'b1; Penable = 1'b0; Paddr = a; Pwrite = w; Pwdata = d; wait_cfg = ws;
    check({nm, ".setup_ready"}, 32'(Pready), 32'd0);
    tick();
    Penable = 1'b1;
    Paddr = $urandom; Pwdata = $urandom; Pwrite = ~w; wait_cfg = 4'($urandom);
    for (int i = 0; i <= int'(ws); i++) begin
      if (i > 0) tick();
      check({nm, ".ready"}, 32'(Pready), 32'(i == int'(ws)));
    end
    check({nm, ".err"}, 32'(Pslverr), 32'(exp_err));
    check({nm, ".rdata"}, Prdata, exp_rd);
    tick();
    mxfer++;
    if (w && !model_err(a, w)) mregs[a[5:2]] = d;
    check({nm, ".post_ready"}, 32'(Pready), 32'd0);
    check({nm, ".xfer_cnt"}, 32'(xfer_cnt), 32'(mxfer[15:0]));
    Psel = 1'b0; Penable = 1'b0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM; i++) mregs[i] = 32'd0;
    mxfer = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  ws;

    tbl[0]  = '{32'h00, 1'b0, 32'h0,         4'd0,  1'b0, ID};
    tbl[1]  = '{32'h04, 1'b1, 32'hDEAD_BEEF, 4'd3,  1'b0, 32'h0};
    tbl[2]  = '{32'h04, 1'b0, 32'h0,         4'd0,  1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{32'h00, 1'b1, 32'h1234_5678, 4'd0,  1'b1, 32'h0};
    tbl[4]  = '{32'h00, 1'b0, 32'h0,         4'd2,  1'b0, ID};
    tbl[5]  = '{32'h40, 1'b0, 32'h0,         4'd0,  1'b1, 32'h0};
    tbl[6]  = '{32'h06, 1'b0, 32'h0,         4'd1,  1'b1, 32'h0};
    tbl[7]  = '{32'h08, 1'b1, 32'hCAFE_F00D, 4'd1,  1'b0, 32'h0};
    tbl[8]  = '{32'h08, 1'b0, 32'h0,         4'd1,  1'b0, 32'hCAFE_F00D};
    tbl[9]  = '{32'h0D, 1'b1, 32'h1111_1111, 4'd0,  1'b1, 32'h0};
    tbl[10] = '{32'h0C, 1'b0, 32'h0,         4'd0,  1'b0, 32'h0};
    tbl[11] = '{32'h3C, 1'b1, 32'h0055_AA00, 4'd4,  1'b0, 32'h0};
    tbl[12] = '{32'h3C, 1'b0, 32'h0,         4'd15, 1'b0, 32'h0055_AA00};

    Presetn = 1'b0; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = '0; Pwdata = '0; wait_cfg = '0;
    reset_model();
    #12;
    check("reset.ready", 32'(Pready), 32'd0);
    check("reset.err", 32'(Pslverr), 32'd0);
    check("reset.rdata", Prdata, 32'd0);
    check("reset.xfer_cnt", 32'(xfer_cnt), 32'd0);
    @(posedge Pclk); #1;
    Presetn = 1'b1;
    tick();

    for (int k = 0; k < 13; k++) begin
      do_xfer(tbl[k].addr, tbl[k].wr, tbl[k].wdata, tbl[k].ws, tbl[k].err, tbl[k].rd,
              $sformatf("vec%0d", k));
      if (k == 9) tick();
    end
    check("table.xfer_total", 32'(xfer_cnt), 32'd13);

    // Write to 0x0C aborted in its 2nd ACCESS cycle by a fresh SETUP (read, zero wait).
    Psel = 1'b1; Penable = 1'b0; Paddr = 32'h0C; Pwrite = 1'b1;
    Pwdata = 32'h0BAD_0BAD; wait_cfg = 4'd5;
    tick();
    Penable = 1'b1;
    check("abort.acc1_ready", 32'(Pready), 32'd0);
    tick();
    check("abort.acc2_ready", 32'(Pready), 32'd0);
    Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h0C; wait_cfg = 4'd0;
    tick();
    check("abort.resetup_ready", 32'(Pready), 32'd1);
    check("abort.resetup_err", 32'(Pslverr), 32'd0);
    check("abort.resetup_rdata", Prdata, model_rd(32'h0C));
    check("abort.no_count", 32'(xfer_cnt), 32'(mxfer[15:0]));
    Penable = 1'b1;
    tick();
    mxfer++;
    check("abort.read_count", 32'(xfer_cnt), 32'(mxfer[15:0]));
    Psel = 1'b0; Penable = 1'b0;
    tick();
    do_xfer(32'h0C, 1'b0, 32'h0, 4'd2, 1'b0, model_rd(32'h0C), "abort.readback");

    for (int n = 0; n < 200; n++) begin
      a = 32'($urandom_range(0, NUM + 1)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      ws = 4'($urandom_range(0, 7));
      do_xfer(a, w, d, ws, model_err(a, w),
              (!w && !model_err(a, w)) ? model_rd(a) : 32'h0, $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset pulse in the middle of a waited write.
    Psel = 1'b1; Penable = 1'b0; Paddr = 32'h10; Pwrite = 1'b1;
    Pwdata = 32'hFEED_FACE; wait_cfg = 4'd3;
    tick();
    Penable = 1'b1;
    tick();
    tick();
    #2 Presetn = 1'b0;
    #1;
    check("midrst.ready", 32'(Pready), 32'd0);
    check("midrst.err", 32'(Pslverr), 32'd0);
    check("midrst.rdata", Prdata, 32'd0);
    check("midrst.xfer_cnt", 32'(xfer_cnt), 32'd0);
    Psel = 1'b0; Penable = 1'b0;
    reset_model();
    @(posedge Pclk); #1;
    Presetn = 1'b1;
    tick();
    for (int i = 0; i < NUM; i++) begin
      a = 32'(i) << 2;
      do_xfer(a, 1'b0, 32'h0, 4'(i % 3), 1'b0, (i == 0) ? ID : 32'h0,
              $sformatf("postrst%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
